// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling default and sample-tick positions.
// Pure declarations, no latency; the receiver has no backpressure.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_WAIT_HIGH
   } uart_state_t;

   localparam int OVERSAMPLE_DEF = 16;

   // Mid-bit samples for the majority vote, and the last tick of a bit period
   localparam int TICK_S0   = 7;
   localparam int TICK_S1   = 8;
   localparam int TICK_S2   = 9;
   localparam int TICK_LAST = 15;

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer for one asynchronous bit; reset value is a parameter.
// Latency two clk; no backpressure.
module bit_sync #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver (8N1 by default) with majority-vote bit sampling, framing/break detection.
// data_strobe one clk after the stop-bit mid-sample tick; no backpressure, a new byte overwrites data.
module uart_rx
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = OVERSAMPLE_DEF,
   parameter int DATA_BITS  = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 baud_x16,
   input  logic                 serial,
   output logic [DATA_BITS-1:0] data,
   output logic                 data_strobe,
   output logic                 framing_error,
   output logic                 break_detect,
   output logic                 busy
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [TW-1:0] T_S0   = TW'(TICK_S0);
   localparam logic [TW-1:0] T_S1   = TW'(TICK_S1);
   localparam logic [TW-1:0] T_S2   = TW'(TICK_S2);
   localparam logic [TW-1:0] T_LAST = (OVERSAMPLE == OVERSAMPLE_DEF) ? TW'(TICK_LAST)
                                                                     : TW'(OVERSAMPLE - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

   uart_state_t          state;
   logic [TW-1:0]        tick;
   logic [TW-1:0]        tick_nxt;
   logic                 tick_last;
   logic [IW-1:0]        idx;
   logic [DATA_BITS-1:0] shreg;
   logic                 samp0;
   logic                 samp1;
   logic                 rx;
   logic                 maj;

   bit_sync #(
      .RESET_VAL (1'b1)
   ) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (serial),
      .q       (rx)
   );

   // The third vote is the live synchronized line at the mid-sample tick
   assign maj       = majority3(samp0, samp1, rx);
   assign tick_last = (tick == T_LAST);
   assign tick_nxt  = tick_last ? '0 : tick + 1'b1;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= ST_IDLE;
         tick          <= '0;
         idx           <= '0;
         shreg         <= '0;
         samp0         <= 1'b0;
         samp1         <= 1'b0;
         data          <= '0;
         data_strobe   <= 1'b0;
         framing_error <= 1'b0;
         break_detect  <= 1'b0;
         busy          <= 1'b0;
      end else begin
         data_strobe   <= 1'b0;
         framing_error <= 1'b0;
         break_detect  <= 1'b0;

         if (baud_x16) begin
            if (tick == T_S0) samp0 <= rx;
            if (tick == T_S1) samp1 <= rx;

            case (state)
               ST_IDLE: begin
                  tick <= '0;
                  if (!rx) begin
                     state <= ST_START;
                     busy  <= 1'b1;
                     shreg <= '0;
                  end
               end

               ST_START: begin
                  tick <= tick_nxt;
                  if (tick == T_S2 && maj) begin
                     // Line recovered before mid-bit: treat as a glitch
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                     tick  <= '0;
                  end else if (tick_last) begin
                     state <= ST_DATA;
                     idx   <= '0;
                  end
               end

               ST_DATA: begin
                  tick <= tick_nxt;
                  if (tick == T_S2) shreg[idx] <= maj;
                  if (tick_last) begin
                     if (idx == IDX_LAST) state <= ST_STOP;
                     else                 idx   <= idx + 1'b1;
                  end
               end

               ST_STOP: begin
                  tick <= tick_nxt;
                  if (tick == T_S2) begin
                     tick <= '0;
                     if (maj) begin
                        data        <= shreg;
                        data_strobe <= 1'b1;
                        state       <= ST_IDLE;
                        busy        <= 1'b0;
                     end else begin
                        framing_error <= 1'b1;
                        break_detect  <= (shreg == '0);
                        state         <= ST_WAIT_HIGH;
                     end
                  end
               end

               ST_WAIT_HIGH: begin
                  tick <= '0;
                  if (rx) begin
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                  end
               end

               default: begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                  tick  <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames push expected events, a negedge monitor pops and compares.
// baud_x16 every 4 clk, so one bit period is 64 clk.
module tb_uart_rx;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       baud_x16 = 1'b0;
   logic       serial = 1'b1;
   logic [7:0] data;
   logic       data_strobe;
   logic       framing_error;
   logic       break_detect;
   logic       busy;

   uart_rx #(
      .OVERSAMPLE (16),
      .DATA_BITS  (8)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .baud_x16      (baud_x16),
      .serial        (serial),
      .data          (data),
      .data_strobe   (data_strobe),
      .framing_error (framing_error),
      .break_detect  (break_detect),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit         ferr;
      bit         brk;
      logic [7:0] val;
   } exp_t;

   exp_t       exp_q[$];
   int         n_checks = 0;
   int         n_fail   = 0;
   int         n_data   = 0;
   int         n_ferr   = 0;
   logic       baud_at_edge = 1'b0;
   logic [7:0] last_good = 8'h00;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   initial begin
      forever begin
         repeat (3) @(posedge clk);
         #1 baud_x16 = 1'b1;
         @(posedge clk);
         #1 baud_x16 = 1'b0;
      end
   end

   always @(posedge clk) baud_at_edge = baud_x16;

   always @(negedge clk) begin : monitor
      exp_t e;
      if (data_strobe || framing_error || break_detect) begin
         if (exp_q.size() == 0) begin
            check("unexpected_pulse", 32'({data_strobe, framing_error, break_detect}), 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("pulse_kind", 32'({data_strobe, framing_error, break_detect}),
                  e.ferr ? 32'({1'b0, 1'b1, e.brk}) : 32'b100);
            check("data_value", 32'(data), 32'(e.val));
            if (!e.ferr) begin
               check("strobe_latency", 32'(baud_at_edge), 32'd1);
               n_data++;
            end else begin
               n_ferr++;
            end
         end
      end
   end

   task automatic hold_bits(input logic v, input int nbits);
      #1 serial = v;
      repeat (nbits * 64) @(posedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      hold_bits(1'b0, 1);
      for (int i = 0; i < 8; i++) hold_bits(b[i], 1);
      hold_bits(stop, 1);
   endtask

   task automatic expect_data(input logic [7:0] b);
      exp_t e;
      e.ferr = 1'b0;
      e.brk  = 1'b0;
      e.val  = b;
      exp_q.push_back(e);
      last_good = b;
   endtask

   task automatic expect_ferr(input bit brk);
      exp_t e;
      e.ferr = 1'b1;
      e.brk  = brk;
      e.val  = last_good;
      exp_q.push_back(e);
   endtask

   initial begin : stimulus
      int guard;

      repeat (5) @(posedge clk);
      #1;
      check("reset_data",   32'(data),          32'd0);
      check("reset_strobe", 32'(data_strobe),   32'd0);
      check("reset_ferr",   32'(framing_error), 32'd0);
      check("reset_break",  32'(break_detect),  32'd0);
      check("reset_busy",   32'(busy),          32'd0);
      #1 reset_n = 1'b1;
      hold_bits(1'b1, 2);

      expect_data(8'h55);
      send_frame(8'h55, 1'b1);
      hold_bits(1'b1, 2);
      check("busy_after_55", 32'(busy), 32'd0);
      check("data_held_55",  32'(data), 32'h55);

      // Back-to-back frames, no idle between stop and next start
      expect_data(8'hA5);
      expect_data(8'h3C);
      send_frame(8'hA5, 1'b1);
      send_frame(8'h3C, 1'b1);
      hold_bits(1'b1, 2);
      check("data_held_3c", 32'(data), 32'h3C);

      // 5-tick low glitch: START entered, then abandoned at mid-bit
      #1 serial = 1'b0;
      repeat (20) @(posedge clk);
      #2 check("glitch_busy", 32'(busy), 32'd1);
      serial = 1'b1;
      repeat (56) @(posedge clk);
      #2 check("glitch_idle", 32'(busy), 32'd0);
      hold_bits(1'b1, 1);

      expect_ferr(1'b0);
      send_frame(8'h81, 1'b0);
      hold_bits(1'b1, 2);
      check("data_kept_81", 32'(data), 32'h3C);
      check("busy_after_81", 32'(busy), 32'd0);

      // Break: 12 bit times low, one framing+break pulse, then a clean frame
      expect_ferr(1'b1);
      hold_bits(1'b0, 12);
      hold_bits(1'b1, 2);
      check("data_kept_break", 32'(data), 32'h3C);
      expect_data(8'h42);
      send_frame(8'h42, 1'b1);
      hold_bits(1'b1, 2);

      // Reset during data bit 4 of 0xFF
      hold_bits(1'b0, 1);
      hold_bits(1'b1, 4);
      #1 serial = 1'b1;
      repeat (32) @(posedge clk);
      #1 check("busy_midframe", 32'(busy), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      check("midreset_busy", 32'(busy), 32'd0);
      check("midreset_data", 32'(data), 32'd0);
      last_good = 8'h00;
      repeat (3) @(posedge clk);
      #2 reset_n = 1'b1;
      hold_bits(1'b1, 4);
      check("busy_after_release", 32'(busy), 32'd0);
      expect_data(8'h0F);
      send_frame(8'h0F, 1'b1);
      hold_bits(1'b1, 2);

      guard = 0;
      while (exp_q.size() != 0 && guard < 2000) begin
         @(posedge clk);
         guard++;
      end
      #1;
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      check("data_count",    32'(n_data),       32'd5);
      check("ferr_count",    32'(n_ferr),       32'd2);
      check("final_data",    32'(data),         32'h0F);
      check("final_busy",    32'(busy),         32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter OVERSAMPLE, default 16, baud_x16 ticks per bit period.
REQ-002 Parameter DATA_BITS, default 8, data bits per frame (LSB first, no parity, 1 stop bit).
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 reset_n  input  1  reset is asynchronous and active-low.
REQ-005 baud_x16  input  1  one-clk-wide enable strobe at OVERSAMPLE x baud rate.
REQ-006 serial  input  1  asynchronous RX line, idle high.
REQ-007 data  output  DATA_BITS  last received byte, held stable until the next data_strobe.
REQ-008 data_strobe  output  1  one-clk pulse, data valid.
REQ-009 framing_error  output  1  one-clk pulse, stop bit sampled low.
REQ-010 break_detect  output  1  one-clk pulse, all data bits and stop bit low.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 serial SHALL pass through a 2-flop synchronizer before any use; both flops reset to 1.
REQ-013 States SHALL be IDLE, START, DATA, STOP, WAIT_HIGH; all counters and the FSM advance only on clk cycles with baud_x16=1.
REQ-014 IDLE: on a tick with synchronized serial=0, go to START with tick counter=0; otherwise remain.
REQ-015 Tick counter SHALL be 4 bits (log2 OVERSAMPLE), counting 0..OVERSAMPLE-1 per bit, wrapping to 0.
REQ-016 Bit value SHALL be the majority of samples taken at ticks 7, 8 and 9 of each bit period.
REQ-017 START: if the majority at tick 9 is 1, the start is false; go to IDLE with no output pulse.
REQ-018 START: at tick 15, go to DATA with bit index=0.
REQ-019 DATA: shift the majority value into bit position [index] at tick 9; at tick 15, increment index; after index DATA_BITS-1, go to STOP.
REQ-020 STOP: at tick 9, if majority=1, load data and pulse data_strobe on the following clk, then go to IDLE immediately, without waiting for ticks 10..15.
REQ-021 STOP: at tick 9, if majority=0, pulse framing_error; data is not updated; go to WAIT_HIGH.
REQ-022 break_detect SHALL pulse in the same cycle as framing_error when the shift register is all zero.
REQ-023 WAIT_HIGH: remain until a tick with synchronized serial=1, then go to IDLE; a break never produces a second start.
REQ-024 Latency: data_strobe SHALL be asserted exactly one clk after the STOP tick-9 baud_x16 cycle.
REQ-025 data_strobe, framing_error and break_detect SHALL never be high simultaneously with each other, except framing_error with break_detect.
REQ-026 baud_x16 held low SHALL freeze all state; glitches shorter than 2 ticks during IDLE SHALL be rejected by REQ-017.

Reset
REQ-027 Asserting reset_n=0 SHALL immediately force: FSM=IDLE, counters=0, shift register=0, data=0, synchronizer=1, and all pulse outputs and busy=0.
REQ-028 Reset asserted mid-frame SHALL discard the partial byte; after release, the receiver resynchronizes only on the next falling edge seen in IDLE.

Structure
REQ-029 A shared package uart_pkg SHALL hold the state enumeration, OVERSAMPLE default and the sample-tick constants (7, 8, 9, 15), shared with uart_tx.
REQ-030 One sub-module, bit_sync (2-flop synchronizer, reset value parameterized), SHALL be instantiated for serial.

Verification
REQ-031 baud_x16 every 4 clk; send 0x55 with a correct stop -> one data_strobe, data=0x55, busy low afterwards.
REQ-032 Back-to-back 0xA5, 0x3C with zero idle bits -> two data_strobe pulses, data=0xA5 then 0x3C, none lost.
REQ-033 Low glitch of 5 ticks in IDLE -> no output pulse; FSM returns to IDLE at start tick 9.
REQ-034 Send 0x81 with the stop bit low -> framing_error pulse only; data retains its previous value.
REQ-035 Hold serial low for 12 bit times, then high -> framing_error and break_detect pulse together once; next frame 0x42 received correctly.
REQ-036 Assert reset_n=0 during data bit 4 of 0xFF, release, then send 0x0F -> data=0x0F only, with a single data_strobe.
